// File: rtl/bits_stream_arbiter_pkg.sv
// Shared types and sizing helpers for the compressed-bits stream arbiter.
package bits_arb_pkg;

   // Decoder bitstream word width.
   localparam int DATA_W_DEF = 64;

   // Packet-level arbitration state.
   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arbState_t;

   // Width of a requester index; never below one bit.
   function automatic int grantWidth(input int numReq);
      return (numReq > 1) ? $clog2(numReq) : 1;
   endfunction

endpackage

// File: rtl/bits_stream_arbiter_if.sv
// Valid/ready stream bundle with LANES parallel channels sharing one
// concatenated tdata vector; lane i occupies tdata[i*DATA_W +: DATA_W].
interface bits_stream_arbiter_if
   import bits_arb_pkg::*;
#(
   parameter int LANES  = 1,
   parameter int DATA_W = DATA_W_DEF
);

   logic [LANES-1:0]        valid;
   logic [LANES*DATA_W-1:0] tdata;
   logic [LANES-1:0]        tlast;
   logic [LANES-1:0]        ready;

   // Producer side of the stream.
   modport master (
      output valid,
      output tdata,
      output tlast,
      input  ready
   );

   // Consumer side of the stream.
   modport slave (
      input  valid,
      input  tdata,
      input  tlast,
      output ready
   );

endinterface

// File: rtl/bits_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: the first eligible requester found
// searching upward from lastGrant+1, wrapping modulo NUM_REQ.
module rr_pick
   import bits_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int GRANT_W = grantWidth(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [GRANT_W-1:0] lastGrant,
   output logic               found,
   output logic [GRANT_W-1:0] pick
);

   logic [NUM_REQ-1:0] rotated;
   logic [GRANT_W-1:0] offset;

   // Rotate so the requester just after lastGrant lands on bit 0.
   always_comb begin
      logic [GRANT_W-1:0] srcIdx;
      rotated = '0;
      srcIdx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         srcIdx     = GRANT_W'((int'(lastGrant) + 1 + k) % NUM_REQ);
         rotated[k] = eligible[srcIdx];
      end
   end

   // Priority-encode: lowest set bit of the rotated vector wins.
   always_comb begin
      found  = 1'b0;
      offset = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rotated[k]) begin
            found  = 1'b1;
            offset = GRANT_W'(k);
         end
      end
   end

   // Undo the rotation to recover the absolute requester index.
   always_comb begin
      pick = GRANT_W'((int'(lastGrant) + 1 + int'(offset)) % NUM_REQ);
   end

endmodule

// File: rtl/bits_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing the decoder's single
// compressed-bits stream between NUM_REQ sources.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no owner; all readies low, output quiet, arbitrate this cycle
//   BURST | granted source passes straight through until its tlast beat
//
// Data is not buffered: in BURST the granted source is wired through with
// zero added latency. Every packet pays one IDLE cycle for arbitration.
module bits_stream_arbiter
   import bits_arb_pkg::*;
#(
   parameter  int NUM_REQ   = 4,
   parameter  int DATA_W    = DATA_W_DEF,
   parameter  int MAX_BEATS = 1024,
   parameter  int CNT_W     = 16,
   localparam int GRANT_W   = grantWidth(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_enable,
   bits_stream_arbiter_if.slave  sBits,
   bits_stream_arbiter_if.master mBits,
   output logic                 busy,
   output logic [GRANT_W-1:0]   grant_id,
   output logic                 pkt_done,
   output logic [CNT_W-1:0]     pkt_count,
   output logic                 err_overlong
);

   localparam int BEAT_W = $clog2(MAX_BEATS + 1);

   arbState_t          state;
   arbState_t          stateNxt;
   logic [GRANT_W-1:0] lastGrant;
   logic [BEAT_W-1:0]  beatCnt;
   logic [NUM_REQ-1:0] eligible;
   logic               pickFound;
   logic [GRANT_W-1:0] pickIdx;
   logic               xfer;
   logic               xferLast;

   assign eligible = req_enable & sBits.valid;
   assign xfer     = (state == BURST) & sBits.valid[grant_id] & mBits.ready[0];
   assign xferLast = xfer & sBits.tlast[grant_id];

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .GRANT_W (GRANT_W)
   ) u_rr_pick (
      .eligible  (eligible),
      .lastGrant (lastGrant),
      .found     (pickFound),
      .pick      (pickIdx)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNxt;
      end
   end

   // Next state and the combinational pass-through from the granted source.
   always_comb begin
      stateNxt    = state;
      busy        = 1'b0;
      sBits.ready = '0;
      mBits.valid = '0;
      mBits.tdata = '0;
      mBits.tlast = '0;
      case (state)
         IDLE: begin
            if (pickFound) begin
               stateNxt = BURST;
            end
         end
         BURST: begin
            busy                  = 1'b1;
            mBits.valid           = sBits.valid[grant_id];
            mBits.tdata           = sBits.tdata[grant_id*DATA_W +: DATA_W];
            mBits.tlast           = sBits.tlast[grant_id];
            sBits.ready[grant_id] = mBits.ready[0];
            if (xferLast) begin
               stateNxt = IDLE;
            end
         end
         default: stateNxt = IDLE;
      endcase
   end

   // Grant bookkeeping, beat counting and per-packet status.
   always_ff @(posedge clk) begin
      if (reset) begin
         lastGrant    <= GRANT_W'(NUM_REQ - 1);
         grant_id     <= '0;
         beatCnt      <= '0;
         pkt_done     <= 1'b0;
         pkt_count    <= '0;
         err_overlong <= 1'b0;
      end else begin
         pkt_done <= 1'b0;
         if ((state == IDLE) && pickFound) begin
            grant_id  <= pickIdx;
            lastGrant <= pickIdx;
            beatCnt   <= '0;
         end
         if (xfer) begin
            // Saturate so a runaway packet cannot wrap back under the limit.
            if (beatCnt != BEAT_W'(MAX_BEATS)) begin
               beatCnt <= beatCnt + 1'b1;
            end
            // The limit beat was not the last one: flag it, keep forwarding.
            if (!xferLast && (beatCnt == BEAT_W'(MAX_BEATS - 1))) begin
               err_overlong <= 1'b1;
            end
            if (xferLast) begin
               pkt_done  <= 1'b1;
               pkt_count <= pkt_count + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bits_stream_arbiter.sv
// Bench for bits_stream_arbiter: queue-backed sources, a packet-level
// reference model of the arbitration rules, and one task per scenario.
module tb_bits_stream_arbiter;

   localparam int NR   = 4;
   localparam int DW   = 64;
   localparam int MAXB = 4;
   localparam int CW   = 4;
   localparam int QD   = 128;

   logic __tb_clk = 1'b0;
   always #5 __tb_clk = ~__tb_clk;

   logic          reset;
   logic [NR-1:0] reqEnable;
   logic          busy;
   logic [1:0]    grantId;
   logic          pktDone;
   logic [CW-1:0] pktCount;
   logic          errOverlong;

   bits_stream_arbiter_if #(.LANES(NR), .DATA_W(DW)) sBus ();
   bits_stream_arbiter_if #(.LANES(1),  .DATA_W(DW)) mBus ();

   bits_stream_arbiter #(
      .NUM_REQ   (NR),
      .DATA_W    (DW),
      .MAX_BEATS (MAXB),
      .CNT_W     (CW)
   ) dut (
      .clk          (__tb_clk),
      .reset        (reset),
      .req_enable   (reqEnable),
      .sBits        (sBus),
      .mBits        (mBus),
      .busy         (busy),
      .grant_id     (grantId),
      .pkt_done     (pktDone),
      .pkt_count    (pktCount),
      .err_overlong (errOverlong)
   );

   // Source packet storage
   logic [DW-1:0] qData [NR][QD];
   logic          qLast [NR][QD];
   int            head [NR];
   int            tail [NR];

   // Reference model
   bit mBusy, mDone, mErr;
   int mOwner, mLast, mCount, mBeat;

   // Observation logs
   logic [DW-1:0] obsQ [$];
   int            grantLog [$];
   int            grantCyc [$];
   int            doneSeen;
   int            cyc;
   int            cycErr;
   string         firstMsg;
   bit            prevBusy;
   bit            chkEn;
   int            pktTotal;

   int tests;
   int failed;

   task automatic modelReset();
      mBusy = 0; mDone = 0; mErr = 0;
      mOwner = 0; mLast = NR - 1; mCount = 0; mBeat = 0;
   endtask

   task automatic flush();
      for (int i = 0; i < NR; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
   endtask

   task automatic clearLogs();
      obsQ.delete();
      grantLog.delete();
      grantCyc.delete();
      doneSeen = 0;
      cycErr   = 0;
   endtask

   task automatic pushPkt(input int r, input int len, input logic [59:0] tag);
      for (int b = 0; b < len; b++) begin
         qData[r][tail[r]] = {4'(r), tag + 60'(b)};
         qLast[r][tail[r]] = (b == len - 1);
         tail[r]++;
      end
   endtask

   function automatic bit anyPending();
      for (int i = 0; i < NR; i++) if (head[i] < tail[i]) return 1'b1;
      return 1'b0;
   endfunction

   // One clock: drive sources, compare against the model at the falling
   // edge, advance the model, then retire accepted beats after the edge.
   task automatic tick();
      logic [NR-1:0]    sv, sl, acc, elig, expR;
      logic [NR*DW-1:0] sd;
      logic             expV, expL;
      logic [DW-1:0]    expD;
      bit               got;
      for (int i = 0; i < NR; i++) begin
         if (head[i] < tail[i]) begin
            sv[i] = 1'b1;
            sd[i*DW +: DW] = qData[i][head[i]];
            sl[i] = qLast[i][head[i]];
         end else begin
            sv[i] = 1'b0;
            sd[i*DW +: DW] = '0;
            sl[i] = 1'b0;
         end
      end
      sBus.valid = sv;
      sBus.tdata = sd;
      sBus.tlast = sl;
      @(negedge __tb_clk);
      if (chkEn) begin
         expV = mBusy ? sBus.valid[mOwner] : 1'b0;
         expD = mBusy ? sBus.tdata[mOwner*DW +: DW] : '0;
         expL = mBusy ? sBus.tlast[mOwner] : 1'b0;
         expR = mBusy ? (NR'(mBus.ready[0]) << mOwner) : '0;
         if (busy !== mBusy || grantId !== 2'(mOwner) || pktDone !== mDone ||
             pktCount !== CW'(mCount) || errOverlong !== mErr ||
             mBus.valid[0] !== expV || mBus.tdata !== expD ||
             mBus.tlast[0] !== expL || sBus.ready !== expR) begin
            cycErr++;
            if (cycErr == 1)
               firstMsg = $sformatf("cyc %0d busy %b/%b grant %0d/%0d done %b/%b count %0d/%0d err %b/%b mvalid %b/%b mdata %h/%h mlast %b/%b sready %b/%b",
                  cyc, busy, mBusy, grantId, mOwner, pktDone, mDone, pktCount, mCount,
                  errOverlong, mErr, mBus.valid[0], expV, mBus.tdata, expD,
                  mBus.tlast[0], expL, sBus.ready, expR);
         end
      end
      if (mBus.valid[0] && mBus.ready[0]) obsQ.push_back(mBus.tdata);
      if (pktDone) doneSeen++;
      if (busy && !prevBusy) begin
         grantLog.push_back(int'(grantId));
         grantCyc.push_back(cyc);
      end
      prevBusy = busy;
      acc = sBus.ready & sBus.valid;
      if (reset) begin
         modelReset();
      end else begin
         mDone = 0;
         if (!mBusy) begin
            elig = reqEnable & sBus.valid;
            got  = 0;
            for (int k = 1; k <= NR; k++) begin
               if (!got && elig[(mLast + k) % NR]) begin
                  got    = 1;
                  mOwner = (mLast + k) % NR;
                  mLast  = mOwner;
                  mBusy  = 1;
                  mBeat  = 0;
               end
            end
         end else if (sBus.valid[mOwner] && mBus.ready[0]) begin
            mBeat++;
            if (!sBus.tlast[mOwner] && mBeat == MAXB) mErr = 1;
            if (sBus.tlast[mOwner]) begin
               mBusy  = 0;
               mDone  = 1;
               mCount = (mCount + 1) % (1 << CW);
            end
         end
      end
      @(posedge __tb_clk);
      #1;
      for (int i = 0; i < NR; i++) if (acc[i]) head[i]++;
      cyc++;
   endtask

   // mode: 0 steady, 1 toggle m_ready, 2 random m_ready, 3 random m_ready and enables
   task automatic drain(input int mode, input int bound, output bit timedOut);
      int n;
      n = 0;
      while ((anyPending() || busy) && n < bound) begin
         case (mode)
            1: mBus.ready[0] = ~mBus.ready[0];
            2: mBus.ready[0] = ($urandom_range(0, 3) != 0);
            3: begin
               mBus.ready[0] = ($urandom_range(0, 3) != 0);
               reqEnable     = NR'($urandom);
            end
            default: ;
         endcase
         tick();
         n++;
      end
      timedOut = anyPending() || busy;
      mBus.ready[0] = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; reqEnable = '1; mBus.ready = 1'b1; chkEn = 0;
      flush();
      clearLogs();
      for (int i = 0; i < NR; i++) pushPkt(i, 3, 60'h1);
      for (int c = 0; c < 3; c++) begin
         tick();
         chkEn = 1;
         tests++;
         if (sBus.ready !== '0) begin failed++; $display("FAIL reset_s_ready c%0d got %b want 0000", c, sBus.ready); end
         tests++;
         if (mBus.valid[0] !== 1'b0) begin failed++; $display("FAIL reset_m_valid c%0d got %b want 0", c, mBus.valid[0]); end
         tests++;
         if (pktCount !== '0) begin failed++; $display("FAIL reset_pkt_count c%0d got %0d want 0", c, pktCount); end
      end
      reset = 1'b0;
      tick();
      tests++;
      if (busy !== 1'b1 || grantId !== 2'd0) begin
         failed++; $display("FAIL reset_first_grant got busy=%b grant=%0d want busy=1 grant=0", busy, grantId);
      end
      reset = 1'b1;
      flush();
      repeat (2) tick();
      reset = 1'b0; pktTotal = 0;
      tests++;
      if (cycErr !== 0) begin failed++; $display("FAIL reset_cycles got %0d bad cycles want 0: %s", cycErr, firstMsg); end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] expQ [$];
      bit to;
      flush(); clearLogs();
      reqEnable = '1; mBus.ready = 1'b1;
      for (int i = 0; i < NR; i++) begin
         pushPkt(i, 3, 60'h1);
         for (int b = 1; b <= 3; b++) expQ.push_back({4'(i), 60'(b)});
      end
      pushPkt(0, 3, 60'h4);
      for (int b = 4; b <= 6; b++) expQ.push_back({4'd0, 60'(b)});
      for (int c = 0; c < 100 && doneSeen < 4; c++) tick();
      tests++;
      if (pktCount !== 4'd4) begin failed++; $display("FAIL b2b_count_round got %0d want 4", pktCount); end
      drain(0, 100, to);
      pktTotal += 5;
      tests++;
      if (to) begin failed++; $display("FAIL b2b_timeout got pending want drained"); end
      tests++;
      if (grantLog.size() != 5) begin
         failed++; $display("FAIL b2b_grant_count got %0d want 5", grantLog.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            tests++;
            if (grantLog[k] != k % NR) begin failed++; $display("FAIL b2b_grant_order[%0d] got %0d want %0d", k, grantLog[k], k % NR); end
            if (k > 0) begin
               tests++;
               if (grantCyc[k] - grantCyc[k-1] != 4) begin failed++; $display("FAIL b2b_period[%0d] got %0d want 4", k, grantCyc[k] - grantCyc[k-1]); end
            end
         end
      end
      tests++;
      if (obsQ.size() != expQ.size()) begin
         failed++; $display("FAIL b2b_beats got %0d want %0d", obsQ.size(), expQ.size());
      end else begin
         for (int k = 0; k < expQ.size(); k++) begin
            tests++;
            if (obsQ[k] !== expQ[k]) begin failed++; $display("FAIL b2b_data[%0d] got %h want %h", k, obsQ[k], expQ[k]); end
         end
      end
      tests++;
      if (pktCount !== CW'(pktTotal)) begin failed++; $display("FAIL b2b_count got %0d want %0d", pktCount, pktTotal % 16); end
      tests++;
      if (cycErr !== 0) begin failed++; $display("FAIL b2b_cycles got %0d bad cycles want 0: %s", cycErr, firstMsg); end
   endtask

   task automatic test_single_beat();
      bit to;
      flush(); clearLogs();
      mBus.ready = 1'b1;
      for (int p = 0; p < 6; p++) pushPkt(2, 1, {28'(p), 32'($urandom)});
      drain(1, 200, to);
      pktTotal += 6;
      tests++;
      if (to) begin failed++; $display("FAIL single_timeout got pending want drained"); end
      tests++;
      if (doneSeen != 6) begin failed++; $display("FAIL single_done got %0d want 6", doneSeen); end
      tests++;
      if (obsQ.size() != 6) begin
         failed++; $display("FAIL single_beats got %0d want 6", obsQ.size());
      end else begin
         for (int k = 0; k < 6; k++) begin
            tests++;
            if (obsQ[k] !== qData[2][k]) begin failed++; $display("FAIL single_data[%0d] got %h want %h", k, obsQ[k], qData[2][k]); end
         end
      end
      for (int k = 1; k < grantCyc.size(); k++) begin
         tests++;
         if (grantCyc[k] - grantCyc[k-1] < 2) begin failed++; $display("FAIL single_period[%0d] got %0d want >=2", k, grantCyc[k] - grantCyc[k-1]); end
      end
      tests++;
      if (pktCount !== CW'(pktTotal)) begin failed++; $display("FAIL single_count got %0d want %0d", pktCount, pktTotal % 16); end
      tests++;
      if (cycErr !== 0) begin failed++; $display("FAIL single_cycles got %0d bad cycles want 0: %s", cycErr, firstMsg); end
   endtask

   task automatic test_grant_hold();
      bit to;
      flush(); clearLogs();
      reqEnable = '1; mBus.ready = 1'b1;
      pushPkt(1, 4, 60'h10);
      for (int c = 0; c < 20 && !busy; c++) tick();
      tests++;
      if (busy !== 1'b1 || grantId !== 2'd1) begin failed++; $display("FAIL hold_grant got busy=%b grant=%0d want busy=1 grant=1", busy, grantId); end
      reqEnable[1] = 1'b0;
      pushPkt(3, 2, 60'h30);
      drain(0, 50, to);
      reqEnable = '1;
      pktTotal += 2;
      tests++;
      if (to) begin failed++; $display("FAIL hold_timeout got pending want drained"); end
      tests++;
      if (grantLog.size() != 2 || grantLog[0] != 1 || grantLog[1] != 3) begin
         failed++; $display("FAIL hold_order got %p want '{1,3}", grantLog);
      end else begin
         tests++;
         if (grantCyc[1] - grantCyc[0] != 5) begin failed++; $display("FAIL hold_gap got %0d want 5", grantCyc[1] - grantCyc[0]); end
      end
      tests++;
      if (obsQ.size() != 6 || obsQ[3] !== {4'd1, 60'h13} || obsQ[4] !== {4'd3, 60'h30}) begin
         failed++; $display("FAIL hold_beats got %0d beats want 6 ordered 1x4 then 3x2", obsQ.size());
      end
      tests++;
      if (cycErr !== 0) begin failed++; $display("FAIL hold_cycles got %0d bad cycles want 0: %s", cycErr, firstMsg); end
   endtask

   task automatic test_random();
      bit to;
      int ptr [NR];
      int bad, total;
      flush(); clearLogs();
      total = 0;
      for (int p = 0; p < 24; p++) begin
         int r, len;
         r   = $urandom_range(0, NR - 1);
         len = $urandom_range(1, MAXB);
         pushPkt(r, len, {28'(p), 32'($urandom)});
         total += len;
      end
      drain(3, 3000, to);
      reqEnable = '1;
      pktTotal += 24;
      tests++;
      if (to) begin failed++; $display("FAIL rand_timeout got pending want drained"); end
      tests++;
      if (doneSeen != 24) begin failed++; $display("FAIL rand_done got %0d want 24", doneSeen); end
      bad = 0;
      for (int i = 0; i < NR; i++) ptr[i] = 0;
      foreach (obsQ[k]) begin
         int r;
         r = int'(obsQ[k][63:60]);
         if (r >= NR || ptr[r] >= tail[r] || obsQ[k] !== qData[r][ptr[r]]) bad++;
         else ptr[r]++;
      end
      tests++;
      if (bad != 0 || obsQ.size() != total) begin
         failed++; $display("FAIL rand_stream got %0d beats %0d out of order want %0d beats 0 out of order", obsQ.size(), bad, total);
      end
      tests++;
      if (pktCount !== CW'(pktTotal)) begin failed++; $display("FAIL rand_count got %0d want %0d", pktCount, pktTotal % 16); end
      tests++;
      if (cycErr !== 0) begin failed++; $display("FAIL rand_cycles got %0d bad cycles want 0: %s", cycErr, firstMsg); end
   endtask

   task automatic test_overlong();
      bit to, c3, c4;
      int n;
      flush(); clearLogs();
      pushPkt(0, 6, 60'h50);
      c3 = 0; c4 = 0; n = 0;
      while ((anyPending() || busy) && n < 100) begin
         mBus.ready[0] = ($urandom_range(0, 2) != 0);
         tick();
         n++;
         if (obsQ.size() == 3 && !c3) begin
            c3 = 1; tests++;
            if (errOverlong !== 1'b0) begin failed++; $display("FAIL overlong_beat3 got %b want 0", errOverlong); end
         end
         if (obsQ.size() == 4 && !c4) begin
            c4 = 1; tests++;
            if (errOverlong !== 1'b1) begin failed++; $display("FAIL overlong_beat4 got %b want 1", errOverlong); end
         end
      end
      drain(0, 10, to);
      pktTotal += 1;
      tests++;
      if (to) begin failed++; $display("FAIL overlong_timeout got pending want drained"); end
      tests++;
      if (errOverlong !== 1'b1) begin failed++; $display("FAIL overlong_sticky got %b want 1", errOverlong); end
      tests++;
      if (obsQ.size() != 6 || obsQ[5] !== {4'd0, 60'h55}) begin failed++; $display("FAIL overlong_beats got %0d want 6", obsQ.size()); end
      tests++;
      if (pktCount !== CW'(pktTotal)) begin failed++; $display("FAIL overlong_count got %0d want %0d", pktCount, pktTotal % 16); end
      tests++;
      if (cycErr !== 0) begin failed++; $display("FAIL overlong_cycles got %0d bad cycles want 0: %s", cycErr, firstMsg); end
   endtask

   task automatic test_reset_mid();
      bit to;
      flush(); clearLogs();
      reqEnable = '1; mBus.ready = 1'b1;
      pushPkt(2, 5, 60'h70);
      for (int c = 0; c < 20 && obsQ.size() < 1; c++) tick();
      reset = 1'b1;
      tick();
      tests++;
      if (busy !== 1'b0 || mBus.valid[0] !== 1'b0 || mBus.tdata !== '0) begin
         failed++; $display("FAIL rstmid_idle got busy=%b mvalid=%b mdata=%h want 0/0/0", busy, mBus.valid[0], mBus.tdata);
      end
      tests++;
      if (pktCount !== '0 || errOverlong !== 1'b0) begin
         failed++; $display("FAIL rstmid_status got count=%0d err=%b want 0/0", pktCount, errOverlong);
      end
      flush();
      reset = 1'b0; pktTotal = 0;
      tick();
      clearLogs();
      pushPkt(1, 2, 60'h81);
      pushPkt(3, 2, 60'h83);
      pushPkt(0, 2, 60'h80);
      drain(0, 50, to);
      pktTotal += 3;
      tests++;
      if (to) begin failed++; $display("FAIL rstmid_timeout got pending want drained"); end
      tests++;
      if (grantLog.size() != 3 || grantLog[0] != 0 || grantLog[1] != 1 || grantLog[2] != 3) begin
         failed++; $display("FAIL rstmid_order got %p want '{0,1,3}", grantLog);
      end
      tests++;
      if (pktCount !== CW'(pktTotal)) begin failed++; $display("FAIL rstmid_count got %0d want %0d", pktCount, pktTotal); end
      tests++;
      if (cycErr !== 0) begin failed++; $display("FAIL rstmid_cycles got %0d bad cycles want 0: %s", cycErr, firstMsg); end
   endtask

   initial begin
      tests = 0; failed = 0; cyc = 0; prevBusy = 0; chkEn = 0; pktTotal = 0;
      reset = 1'b1; reqEnable = '1;
      sBus.valid = '0; sBus.tdata = '0; sBus.tlast = '0;
      mBus.ready = 1'b1;
      modelReset();
      flush();
      clearLogs();
      test_reset();
      test_back_to_back();
      test_single_beat();
      test_grant_hold();
      test_random();
      test_overlong();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
